lsu_req_fsm: RTL and testbench

LSU_REQ_FSM -- requirements
Module: lsu_req_fsm

---
 rtl/lsu_req_if.sv | 36 +++
 rtl/lsu_req_fsm.sv | 139 +++++++++++++
 tb/tb_lsu_req_fsm.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_req_if.sv
// Request/response/memory bundle for the LSU request sequencer.
// slave = the sequencer side, master = core/memory environment side.
interface lsu_req_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_wen;
    logic [2:0]  req_funct3;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;

    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_rdata;
    logic        resp_err;

    logic        mem_en;
    logic        mem_rw;
    logic [63:0] mem_addr;
    logic [3:0]  mem_len;
    logic [63:0] mem_dataIn;
    logic [63:0] mem_dataOut;

    modport slave (
        input  req_valid, req_wen, req_funct3, req_addr, req_wdata,
        input  resp_ready, mem_dataOut,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_en, mem_rw, mem_addr, mem_len, mem_dataIn
    );

    modport master (
        output req_valid, req_wen, req_funct3, req_addr, req_wdata,
        output resp_ready, mem_dataOut,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mem_en, mem_rw, mem_addr, mem_len, mem_dataIn
    );
endinterface

// File: rtl/lsu_req_fsm.sv
// Single-outstanding load/store sequencer: capture, one-cycle memory issue, fixed-latency wait, response hold.
// Define LSU_MISALIGN_CHECK_EN to reject accesses whose address is not aligned to their length.
//
// state    | meaning
// ST_IDLE  | ready for a request; captures it on req_valid
// ST_ISSUE | single-cycle memory strobe from captured request
// ST_WAIT  | down-count LATENCY-1..0, sample mem_dataOut at 0
// ST_RESP  | hold response until resp_ready
module lsu_req_fsm #(
    parameter int unsigned LATENCY = 1
) (
    input logic     clk,
    input logic     rst_n,
    lsu_req_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  cnt_q;
    logic        wen_q;
    logic [2:0]  funct3_q;
    logic [63:0] addr_q;
    logic [63:0] wdata_q;
    logic [3:0]  len_q;
    logic [63:0] rdata_q;
    logic        err_q;

    logic        accept;
    logic        sample;
    logic        illegal_type;
    logic        illegal;
    logic [3:0]  len_req;
    logic [63:0] load_ext;

    assign len_req      = 4'd1 << bus.req_funct3[1:0];
    assign illegal_type = bus.req_wen ? bus.req_funct3[2] : (bus.req_funct3 == 3'b111);

`ifdef LSU_MISALIGN_CHECK_EN
    logic misalign;
    assign misalign = (bus.req_addr[3:0] & (len_req - 4'd1)) != 4'd0;
    assign illegal  = illegal_type | misalign;
`else
    assign illegal  = illegal_type;
`endif

    assign accept = (state == ST_IDLE) && bus.req_valid;
    assign sample = (state == ST_WAIT) && (cnt_q == 4'd0);

    always_comb begin
        load_ext = 64'd0;
        case (funct3_q)
            3'b000:  load_ext = {{56{bus.mem_dataOut[7]}},  bus.mem_dataOut[7:0]};
            3'b001:  load_ext = {{48{bus.mem_dataOut[15]}}, bus.mem_dataOut[15:0]};
            3'b010:  load_ext = {{32{bus.mem_dataOut[31]}}, bus.mem_dataOut[31:0]};
            3'b011:  load_ext = bus.mem_dataOut;
            3'b100:  load_ext = {56'd0, bus.mem_dataOut[7:0]};
            3'b101:  load_ext = {48'd0, bus.mem_dataOut[15:0]};
            3'b110:  load_ext = {32'd0, bus.mem_dataOut[31:0]};
            default: load_ext = 64'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt      = state;
        bus.req_ready  = 1'b0;
        bus.mem_en     = 1'b0;
        bus.resp_valid = 1'b0;
        case (state)
            ST_IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) state_nxt = illegal ? ST_RESP : ST_ISSUE;
            end
            ST_ISSUE: begin
                bus.mem_en = 1'b1;
                state_nxt  = ST_WAIT;
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) state_nxt = ST_RESP;
            end
            ST_RESP: begin
                bus.resp_valid = 1'b1;
                if (bus.resp_ready) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= 4'd0;
            wen_q    <= 1'b0;
            funct3_q <= 3'd0;
            addr_q   <= 64'd0;
            wdata_q  <= 64'd0;
            len_q    <= 4'd0;
            rdata_q  <= 64'd0;
            err_q    <= 1'b0;
        end else begin
            if (accept) begin
                wen_q    <= bus.req_wen;
                funct3_q <= bus.req_funct3;
                addr_q   <= bus.req_addr;
                wdata_q  <= bus.req_wdata;
                len_q    <= len_req;
                err_q    <= illegal;
                rdata_q  <= 64'd0;
            end
            if (state == ST_ISSUE)
                cnt_q <= CNT_INIT;
            else if ((state == ST_WAIT) && (cnt_q != 4'd0))
                cnt_q <= cnt_q - 4'd1;
            // Stores complete with zero data; loads return the extended memory word.
            if (sample)
                rdata_q <= wen_q ? 64'd0 : load_ext;
        end
    end

    assign bus.mem_rw     = wen_q;
    assign bus.mem_addr   = addr_q;
    assign bus.mem_len    = len_q;
    assign bus.mem_dataIn = wdata_q;
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = err_q;

endmodule

// File: tb/tb_lsu_req_fsm.sv
// Directed bench for lsu_req_fsm: vector table on a LATENCY=1 instance, hand sequences
// for backpressure and reset abort, and a LATENCY=4 instance for the wait-counter cases.
module tb_lsu_req_fsm;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst1_n;
    logic        rst4_n;
    logic        sel4;
    logic        req_valid;
    logic        req_wen;
    logic [2:0]  req_funct3;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic        resp_ready;
    logic [63:0] mem_data;

    lsu_req_if bus1();
    lsu_req_if bus4();

    assign bus1.req_valid   = req_valid;
    assign bus1.req_wen     = req_wen;
    assign bus1.req_funct3  = req_funct3;
    assign bus1.req_addr    = req_addr;
    assign bus1.req_wdata   = req_wdata;
    assign bus1.resp_ready  = resp_ready;
    assign bus1.mem_dataOut = mem_data;
    assign bus4.req_valid   = req_valid;
    assign bus4.req_wen     = req_wen;
    assign bus4.req_funct3  = req_funct3;
    assign bus4.req_addr    = req_addr;
    assign bus4.req_wdata   = req_wdata;
    assign bus4.resp_ready  = resp_ready;
    assign bus4.mem_dataOut = mem_data;

    lsu_req_fsm #(.LATENCY(1)) dut  (.clk(clk), .rst_n(rst1_n), .bus(bus1));
    lsu_req_fsm #(.LATENCY(4)) dut4 (.clk(clk), .rst_n(rst4_n), .bus(bus4));

    logic        m_req_ready, m_resp_valid, m_resp_err, m_mem_en, m_mem_rw;
    logic [63:0] m_resp_rdata, m_mem_addr, m_mem_dataIn;
    logic [3:0]  m_mem_len;
    assign m_req_ready  = sel4 ? bus4.req_ready  : bus1.req_ready;
    assign m_resp_valid = sel4 ? bus4.resp_valid : bus1.resp_valid;
    assign m_resp_err   = sel4 ? bus4.resp_err   : bus1.resp_err;
    assign m_resp_rdata = sel4 ? bus4.resp_rdata : bus1.resp_rdata;
    assign m_mem_en     = sel4 ? bus4.mem_en     : bus1.mem_en;
    assign m_mem_rw     = sel4 ? bus4.mem_rw     : bus1.mem_rw;
    assign m_mem_addr   = sel4 ? bus4.mem_addr   : bus1.mem_addr;
    assign m_mem_len    = sel4 ? bus4.mem_len    : bus1.mem_len;
    assign m_mem_dataIn = sel4 ? bus4.mem_dataIn : bus1.mem_dataIn;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        wen;
        logic [2:0]  f3;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] mdata;
        logic        err;
        logic        issue;
        logic [3:0]  len;
        logic [63:0] rdata;
    } vec_t;

    function automatic vec_t mk(input logic wen, input logic [2:0] f3, input logic [63:0] addr,
                                input logic [63:0] wdata, input logic [63:0] mdata, input logic err,
                                input logic issue, input logic [3:0] len, input logic [63:0] rdata);
        vec_t v;
        v.wen = wen; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.mdata = mdata;
        v.err = err; v.issue = issue; v.len = len; v.rdata = rdata;
        return v;
    endfunction

    // One complete transaction; expects resp_valid LATENCY+2 cycles after accept (1 on error).
    task automatic run_txn(input vec_t v, input int lat, input string tag);
        int k;
        int pulses;
        bit got;
        @(negedge clk);
        req_wen = v.wen; req_funct3 = v.f3; req_addr = v.addr; req_wdata = v.wdata;
        mem_data = v.mdata; resp_ready = 1'b0; req_valid = 1'b1;
        chk({tag, " req_ready idle"}, 64'(m_req_ready), 64'd1);
        k = 0; pulses = 0; got = 1'b0;
        while (!got && k < 40) begin
            @(negedge clk);
            req_valid = 1'b0;
            k++;
            if (m_mem_en) begin
                pulses++;
                chk({tag, " mem_rw"},   64'(m_mem_rw),  64'(v.wen));
                chk({tag, " mem_addr"}, m_mem_addr,     v.addr);
                chk({tag, " mem_len"},  64'(m_mem_len), 64'(v.len));
                if (v.wen) chk({tag, " mem_dataIn"}, m_mem_dataIn, v.wdata);
            end
            if (m_resp_valid) got = 1'b1;
        end
        chk({tag, " resp latency"}, 64'(k), v.issue ? 64'(lat + 2) : 64'd1);
        chk({tag, " mem_en pulses"}, 64'(pulses), 64'(v.issue));
        chk({tag, " resp_rdata"}, m_resp_rdata, v.rdata);
        chk({tag, " resp_err"}, 64'(m_resp_err), 64'(v.err));
        chk({tag, " req_ready in resp"}, 64'(m_req_ready), 64'd0);
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        chk({tag, " resp_valid after hs"}, 64'(m_resp_valid), 64'd0);
        chk({tag, " req_ready after hs"}, 64'(m_req_ready), 64'd1);
    endtask

    vec_t vecs[15];

    initial begin
        int stale;
        bit got;
        sel4 = 1'b0; rst1_n = 1'b0; rst4_n = 1'b0;
        req_valid = 1'b0; req_wen = 1'b0; req_funct3 = 3'd0; req_addr = 64'd0;
        req_wdata = 64'd0; resp_ready = 1'b0; mem_data = 64'd0;

        vecs[0]  = mk(0, 3'b000, 64'h80000003, 0, 64'h00000000000000F0, 0, 1, 4'd1, 64'hFFFFFFFFFFFFFFF0);
        vecs[1]  = mk(0, 3'b110, 64'h80000004, 0, 64'h0000000080000001, 0, 1, 4'd4, 64'h0000000080000001);
        vecs[2]  = mk(1, 3'b011, 64'h80000008, 64'h1122334455667788, 64'hDEADBEEFDEADBEEF, 0, 1, 4'd8, 64'd0);
        vecs[3]  = mk(0, 3'b001, 64'h10, 0, 64'h0000000000008001, 0, 1, 4'd2, 64'hFFFFFFFFFFFF8001);
        vecs[4]  = mk(0, 3'b010, 64'h20, 0, 64'hAAAAAAAA80000000, 0, 1, 4'd4, 64'hFFFFFFFF80000000);
        vecs[5]  = mk(0, 3'b011, 64'h28, 0, 64'h0123456789ABCDEF, 0, 1, 4'd8, 64'h0123456789ABCDEF);
        vecs[6]  = mk(0, 3'b100, 64'h31, 0, 64'hFFFFFFFFFFFFFF80, 0, 1, 4'd1, 64'h0000000000000080);
        vecs[7]  = mk(0, 3'b101, 64'h32, 0, 64'h123456789ABCFEDC, 0, 1, 4'd2, 64'h000000000000FEDC);
        vecs[8]  = mk(0, 3'b000, 64'h33, 0, 64'h123456789ABCDE7F, 0, 1, 4'd1, 64'h000000000000007F);
        vecs[9]  = mk(0, 3'b111, 64'h40, 0, 64'hFFFFFFFFFFFFFFFF, 1, 0, 4'd0, 64'd0);
        vecs[10] = mk(1, 3'b100, 64'h48, 64'h55, 64'h0, 1, 0, 4'd0, 64'd0);
        vecs[11] = mk(1, 3'b111, 64'h50, 64'h66, 64'h0, 1, 0, 4'd0, 64'd0);
        vecs[12] = mk(1, 3'b000, 64'h53, 64'h00000000000000AB, 64'h0, 0, 1, 4'd1, 64'd0);
`ifdef LSU_MISALIGN_CHECK_EN
        vecs[13] = mk(0, 3'b010, 64'h80000002, 0, 64'h0000000012345678, 1, 0, 4'd4, 64'd0);
        vecs[14] = mk(0, 3'b001, 64'h61, 0, 64'h0000000000009000, 1, 0, 4'd2, 64'd0);
`else
        vecs[13] = mk(0, 3'b010, 64'h80000002, 0, 64'h0000000012345678, 0, 1, 4'd4, 64'h0000000012345678);
        vecs[14] = mk(0, 3'b001, 64'h61, 0, 64'h0000000000009000, 0, 1, 4'd2, 64'hFFFFFFFFFFFF9000);
`endif

        #12;
        chk("rst req_ready",  64'(bus1.req_ready),  64'd1);
        chk("rst resp_valid", 64'(bus1.resp_valid), 64'd0);
        chk("rst resp_err",   64'(bus1.resp_err),   64'd0);
        chk("rst resp_rdata", bus1.resp_rdata,      64'd0);
        chk("rst mem_en",     64'(bus1.mem_en),     64'd0);
        chk("rst mem_rw",     64'(bus1.mem_rw),     64'd0);
        chk("rst mem_addr",   bus1.mem_addr,        64'd0);
        chk("rst mem_len",    64'(bus1.mem_len),    64'd0);
        chk("rst mem_dataIn", bus1.mem_dataIn,      64'd0);
        @(negedge clk);
        rst1_n = 1'b1;

        for (int i = 0; i < 15; i++)
            run_txn(vecs[i], 1, $sformatf("v%0d", i));

        // Backpressure: response held, second request waits until one cycle after handshake.
        @(negedge clk);
        req_wen = 1'b0; req_funct3 = 3'b010; req_addr = 64'h100;
        mem_data = 64'hFFFFFFFFCAFEF00D; req_valid = 1'b1; resp_ready = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            req_valid = 1'b0;
            if (bus1.resp_valid) got = 1'b1;
        end
        chk("bp resp_valid seen", 64'(got), 64'd1);
        req_funct3 = 3'b011; req_addr = 64'h200; mem_data = 64'h55; req_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("bp%0d resp_valid", k), 64'(bus1.resp_valid), 64'd1);
            chk($sformatf("bp%0d resp_rdata", k), bus1.resp_rdata, 64'hFFFFFFFFCAFEF00D);
            chk($sformatf("bp%0d req_ready", k),  64'(bus1.req_ready), 64'd0);
            chk($sformatf("bp%0d mem_en", k),     64'(bus1.mem_en), 64'd0);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        chk("bp hs resp_valid", 64'(bus1.resp_valid), 64'd0);
        chk("bp hs req_ready",  64'(bus1.req_ready),  64'd1);
        chk("bp hs mem_en",     64'(bus1.mem_en),     64'd0);
        @(negedge clk);
        req_valid = 1'b0;
        chk("bp 2nd mem_en",   64'(bus1.mem_en),   64'd1);
        chk("bp 2nd mem_addr", bus1.mem_addr,      64'h200);
        chk("bp 2nd mem_len",  64'(bus1.mem_len),  64'd8);
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (bus1.resp_valid) got = 1'b1;
        end
        chk("bp 2nd resp seen",  64'(got), 64'd1);
        chk("bp 2nd resp_rdata", bus1.resp_rdata, 64'h55);
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;

        // Reset during ISSUE drops mem_en without a clock edge.
        @(negedge clk);
        req_wen = 1'b0; req_funct3 = 3'b011; req_addr = 64'h300; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        chk("abort1 mem_en before", 64'(bus1.mem_en), 64'd1);
        #2 rst1_n = 1'b0;
        #1;
        chk("abort1 mem_en",     64'(bus1.mem_en),     64'd0);
        chk("abort1 resp_valid", 64'(bus1.resp_valid), 64'd0);
        chk("abort1 req_ready",  64'(bus1.req_ready),  64'd1);
        @(negedge clk);
        rst1_n = 1'b1;
        stale = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (bus1.resp_valid || bus1.mem_en || !bus1.req_ready) stale++;
        end
        chk("abort1 stale cycles", 64'(stale), 64'd0);

        // LATENCY=4 instance: timing, then reset during WAIT.
        sel4 = 1'b1;
        rst1_n = 1'b0;
        @(negedge clk);
        rst4_n = 1'b1;
        run_txn(mk(0, 3'b000, 64'h400, 0, 64'h05, 0, 1, 4'd1, 64'h05), 4, "L4a");
        @(negedge clk);
        req_wen = 1'b0; req_funct3 = 3'b010; req_addr = 64'h404; mem_data = 64'h80000000; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("abort4 in wait resp_valid", 64'(bus4.resp_valid), 64'd0);
        #2 rst4_n = 1'b0;
        #1;
        chk("abort4 mem_en",     64'(bus4.mem_en),     64'd0);
        chk("abort4 resp_valid", 64'(bus4.resp_valid), 64'd0);
        chk("abort4 req_ready",  64'(bus4.req_ready),  64'd1);
        chk("abort4 resp_err",   64'(bus4.resp_err),   64'd0);
        @(negedge clk);
        rst4_n = 1'b1;
        stale = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (bus4.resp_valid || bus4.mem_en || !bus4.req_ready) stale++;
        end
        chk("abort4 stale cycles", 64'(stale), 64'd0);
        run_txn(mk(0, 3'b001, 64'h406, 0, 64'h0000000000007FFF, 0, 1, 4'd2, 64'h7FFF), 4, "L4b");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
